// File: rtl/ext_rx_pkg.sv
// ext_rx_pkg
// Shared types and constants for the external-board RX packetizer.
//   ext_rx_state_t : framing FSM states (IDLE, WAIT2, HOLD)
//   PKT_LEN1/2     : encodings of the pkt_len2 output
//   PKT_PAD_BYTE   : value reported in pkt_byte2 for single-byte packets
package ext_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT2 = 2'd1,
        HOLD  = 2'd2
    } ext_rx_state_t;

    localparam logic       PKT_LEN1     = 1'b0;
    localparam logic       PKT_LEN2     = 1'b1;
    localparam logic [7:0] PKT_PAD_BYTE = 8'h00;

endpackage

// File: rtl/ext_rx_packetizer_byte_fifo.sv
// byte_fifo
// Small show-ahead FIFO used for the forward byte stream.
//   clk, rst_n  : clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data : write request and data; accepted when not full or
//                     when a pop happens in the same cycle
//   pop         : remove head; ignored when empty
//   head        : current head entry, 0 while empty
//   empty, full : occupancy flags
module byte_fifo
    import ext_rx_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      count;
    logic             pop_ok;
    logic             push_ok;

    assign count   = wr_q - rd_q;
    assign empty   = (wr_q == rd_q);
    assign full    = (count == DEPTH_L);
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees a slot, so a push at full still fits.
    assign push_ok = push && (!full || pop_ok);
    assign head    = empty ? '0 : mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wr_q[AW-1:0]] = push_data;
            wr_d = wr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/ext_rx_packetizer.sv
// ext_rx_packetizer
// Receive-side framing stage behind the external-board UART RX.
// Every received byte goes into a forward FIFO; in parallel a framing FSM
// builds one- or two-byte packets (second byte or inter-byte timeout closes
// a packet) and holds them until the routing FSM acknowledges.
//
// Handshakes: a transfer happens in any cycle where valid && ready are both
// high at the rising clock edge; valid and the payload stay stable until then.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   rx_dv, rx_byte      : one-cycle received-byte strobe and data
//   fwd_valid/byte/ready: show-ahead forward stream
//   fwd_ovf, ovf_clr    : sticky FIFO overflow flag and its clear
//   pkt_valid/len2/byte1/byte2/ready : framed packet and handshake
//   pkt_count, pkt_drop_count        : statistics
//
// Build option: define EXT_RX_PKT_STATS_EN to include the statistics
// counters; without it pkt_count and pkt_drop_count are tied to 0.
module ext_rx_packetizer
    import ext_rx_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = 25_000_000,
    parameter int TIMEOUT_CYCLES = CLK_FREQ_HZ / 1000,
    parameter int FWD_DEPTH      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_dv,
    input  logic [7:0]  rx_byte,
    output logic        fwd_valid,
    output logic [7:0]  fwd_byte,
    input  logic        fwd_ready,
    output logic        fwd_ovf,
    input  logic        ovf_clr,
    output logic        pkt_valid,
    output logic        pkt_len2,
    output logic [7:0]  pkt_byte1,
    output logic [7:0]  pkt_byte2,
    input  logic        pkt_ready,
    output logic [15:0] pkt_count,
    output logic [15:0] pkt_drop_count
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    // ---------------- forward path ----------------
    logic fifo_empty;
    logic fifo_full;
    logic ovf_q, ovf_d;

    byte_fifo #(
        .DEPTH (FWD_DEPTH),
        .WIDTH (8)
    ) u_fwd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rx_dv),
        .push_data (rx_byte),
        .pop       (fwd_ready),
        .head      (fwd_byte),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign fwd_valid = !fifo_empty;

    // Full implies non-empty, so a ready consumer always makes room.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (rx_dv && fifo_full && !fwd_ready) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign fwd_ovf = ovf_q;

    // ---------------- framing FSM ----------------
    ext_rx_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    byte1_q, byte1_d;
    logic [7:0]    byte2_q, byte2_d;
    logic          len2_q, len2_d;
    logic          pkt_hs;

    assign pkt_hs = (state_q == HOLD) && pkt_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        byte1_d = byte1_q;
        byte2_d = byte2_q;
        len2_d  = len2_q;
        case (state_q)
            IDLE: begin
                if (rx_dv) begin
                    byte1_d = rx_byte;
                    cnt_d   = '0;
                    state_d = WAIT2;
                end
            end
            WAIT2: begin
                // A byte arriving on the timeout cycle still completes the pair.
                if (rx_dv) begin
                    byte2_d = rx_byte;
                    len2_d  = PKT_LEN2;
                    state_d = HOLD;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    byte2_d = PKT_PAD_BYTE;
                    len2_d  = PKT_LEN1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (pkt_hs) begin
                    if (rx_dv) begin
                        byte1_d = rx_byte;
                        cnt_d   = '0;
                        state_d = WAIT2;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            byte1_q <= '0;
            byte2_q <= '0;
            len2_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            byte1_q <= byte1_d;
            byte2_q <= byte2_d;
            len2_q  <= len2_d;
        end
    end

    assign pkt_valid = (state_q == HOLD);
    assign pkt_len2  = len2_q;
    assign pkt_byte1 = byte1_q;
    assign pkt_byte2 = byte2_q;

    // ---------------- statistics ----------------
`ifdef EXT_RX_PKT_STATS_EN
    logic [15:0] pkt_cnt_q, pkt_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (pkt_hs) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
        // Byte seen while a packet is still waiting: forwarded, not framed.
        if ((state_q == HOLD) && !pkt_ready && rx_dv) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pkt_count      = pkt_cnt_q;
    assign pkt_drop_count = drop_cnt_q;
`else
    assign pkt_count      = '0;
    assign pkt_drop_count = '0;
`endif

endmodule

// File: tb/tb_ext_rx_packetizer.sv
// Directed bench for ext_rx_packetizer with TIMEOUT_CYCLES=16, FWD_DEPTH=4.
module tb_ext_rx_packetizer;
    import ext_rx_pkg::*;

    localparam int TO    = 16;
    localparam int DEPTH = 4;
`ifdef EXT_RX_PKT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_dv = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        fwd_ready = 1'b0;
    logic        ovf_clr = 1'b0;
    logic        pkt_ready = 1'b0;
    logic        fwd_valid;
    logic [7:0]  fwd_byte;
    logic        fwd_ovf;
    logic        pkt_valid;
    logic        pkt_len2;
    logic [7:0]  pkt_byte1;
    logic [7:0]  pkt_byte2;
    logic [15:0] pkt_count;
    logic [15:0] pkt_drop_count;

    always #5 clk = ~clk;

    ext_rx_packetizer #(
        .CLK_FREQ_HZ    (25_000_000),
        .TIMEOUT_CYCLES (TO),
        .FWD_DEPTH      (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_dv          (rx_dv),
        .rx_byte        (rx_byte),
        .fwd_valid      (fwd_valid),
        .fwd_byte       (fwd_byte),
        .fwd_ready      (fwd_ready),
        .fwd_ovf        (fwd_ovf),
        .ovf_clr        (ovf_clr),
        .pkt_valid      (pkt_valid),
        .pkt_len2       (pkt_len2),
        .pkt_byte1      (pkt_byte1),
        .pkt_byte2      (pkt_byte2),
        .pkt_ready      (pkt_ready),
        .pkt_count      (pkt_count),
        .pkt_drop_count (pkt_drop_count)
    );

    // ---------------- scoreboard ----------------
    logic [7:0]  exp_q[$];
    logic        exp_ovf = 1'b0;
    logic [15:0] exp_pkt = '0;
    logic [15:0] exp_drop = '0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Strobe one byte; model the FIFO push (drop and flag when full).
    task automatic send(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        tick();
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else exp_ovf = 1'b1;
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            check(tag, {15'd0, fwd_valid}, 16'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_valid"}, {15'd0, fwd_valid}, 16'd1);
            check(tag, {8'd0, fwd_byte}, {8'd0, e});
            fwd_ready = 1'b1;
            tick();
            fwd_ready = 1'b0;
        end
    endtask

    task automatic handshake(input string tag);
        pkt_ready = 1'b1;
        tick();
        pkt_ready = 1'b0;
        exp_pkt += 16'(STATS);
        check({tag, "_vlow"}, {15'd0, pkt_valid}, 16'd0);
        check({tag, "_cnt"}, pkt_count, exp_pkt);
    endtask

    task automatic check_pkt(input string tag, input logic len2, input logic [7:0] b1, input logic [7:0] b2);
        check({tag, "_valid"}, {15'd0, pkt_valid}, 16'd1);
        check({tag, "_len2"}, {15'd0, pkt_len2}, {15'd0, len2});
        check({tag, "_b1"}, {8'd0, pkt_byte1}, {8'd0, b1});
        check({tag, "_b2"}, {8'd0, pkt_byte2}, {8'd0, b2});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fwd_valid"}, {15'd0, fwd_valid}, 16'd0);
        check({tag, "_fwd_byte"}, {8'd0, fwd_byte}, 16'd0);
        check({tag, "_fwd_ovf"}, {15'd0, fwd_ovf}, 16'd0);
        check({tag, "_pkt_valid"}, {15'd0, pkt_valid}, 16'd0);
        check({tag, "_pkt_len2"}, {15'd0, pkt_len2}, 16'd0);
        check({tag, "_pkt_b1"}, {8'd0, pkt_byte1}, 16'd0);
        check({tag, "_pkt_b2"}, {8'd0, pkt_byte2}, 16'd0);
        check({tag, "_pkt_cnt"}, pkt_count, 16'd0);
        check({tag, "_drop_cnt"}, pkt_drop_count, 16'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int bad;

        // Reset state
        ticks(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Two-byte packet: 0x41 then 0x37 five cycles later
        send(8'h41);
        check("two_fwd_valid", {15'd0, fwd_valid}, 16'd1);
        check("two_fwd_byte", {8'd0, fwd_byte}, 16'h41);
        ticks(4);
        check("two_not_yet", {15'd0, pkt_valid}, 16'd0);
        send(8'h37);
        check_pkt("two", 1'b1, 8'h41, 8'h37);
        pop_check("two_pop0");
        pop_check("two_pop1");
        check("two_fifo_empty", {15'd0, fwd_valid}, 16'd0);
        handshake("two_hs");

        // Single-byte packet closed by timeout
        send(8'h5A);
        n = 0;
        while (!pkt_valid && n < 40) begin
            tick();
            n++;
        end
        check("single_latency", 16'(n), 16'(TO));
        check_pkt("single", 1'b0, 8'h5A, 8'h00);
        pop_check("single_pop");

        // Packet held while pkt_ready stays low
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (pkt_valid !== 1'b1 || pkt_len2 !== 1'b0 || pkt_byte1 !== 8'h5A || pkt_byte2 !== 8'h00)
                bad++;
        end
        check("hold_stable", 16'(bad), 16'd0);
        send(8'h11);
        exp_drop += 16'(STATS);
        check("hold_fwd_byte", {8'd0, fwd_byte}, 16'h11);
        check("hold_drop_cnt", pkt_drop_count, exp_drop);
        check_pkt("hold_after", 1'b0, 8'h5A, 8'h00);
        pop_check("hold_pop");
        handshake("hold_hs");

        // Overflow: 0x01..0x05 with no consumer
        for (int i = 1; i <= 5; i++) send(8'(i));
        exp_drop += 16'(3 * STATS);
        check("ovf_set", {15'd0, fwd_ovf}, {15'd0, exp_ovf});
        check("ovf_head", {8'd0, fwd_byte}, 16'h01);
        check("ovf_drop_cnt", pkt_drop_count, exp_drop);
        // Clear coinciding with another overflow: set wins
        ovf_clr = 1'b1;
        send(8'h07);
        ovf_clr = 1'b0;
        exp_drop += 16'(STATS);
        check("ovf_set_wins", {15'd0, fwd_ovf}, 16'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        exp_ovf = 1'b0;
        check("ovf_clr", {15'd0, fwd_ovf}, 16'd0);
        // Push at full with simultaneous pop is accepted
        fwd_ready = 1'b1;
        rx_dv     = 1'b1;
        rx_byte   = 8'h06;
        tick();
        rx_dv     = 1'b0;
        fwd_ready = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(8'h06);
        exp_drop += 16'(STATS);
        check("ovf_pushpop_no_ovf", {15'd0, fwd_ovf}, 16'd0);
        check("ovf_pushpop_head", {8'd0, fwd_byte}, 16'h02);
        check_pkt("ovf_pkt", 1'b1, 8'h01, 8'h02);
        for (int i = 0; i < 4; i++) pop_check("ovf_drain");
        check("ovf_drained", {15'd0, fwd_valid}, 16'd0);
        check("ovf_drop_final", pkt_drop_count, exp_drop);
        handshake("ovf_hs");

        // Second byte on the exact timeout cycle
        send(8'h21);
        ticks(TO - 1);
        check("edge_not_yet", {15'd0, pkt_valid}, 16'd0);
        send(8'h22);
        check_pkt("edge", 1'b1, 8'h21, 8'h22);
        // rx_dv together with the handshake starts a new packet
        pkt_ready = 1'b1;
        send(8'h33);
        pkt_ready = 1'b0;
        exp_pkt += 16'(STATS);
        check("hsdv_vlow", {15'd0, pkt_valid}, 16'd0);
        check("hsdv_cnt", pkt_count, exp_pkt);
        send(8'h34);
        check_pkt("hsdv", 1'b1, 8'h33, 8'h34);
        handshake("hsdv_hs");
        for (int i = 0; i < 4; i++) pop_check("edge_drain");

        // Reset during WAIT2 with 3 bytes queued
        send(8'hA1);
        send(8'hA2);
        pkt_ready = 1'b1;
        send(8'hA3);
        pkt_ready = 1'b0;
        exp_pkt += 16'(STATS);
        check("rst_pre_wait2", {15'd0, pkt_valid}, 16'd0);
        check("rst_pre_fifo", {8'd0, fwd_byte}, 16'hA1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_async");
        exp_q.delete();
        exp_pkt  = '0;
        exp_drop = '0;
        exp_ovf  = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        send(8'h55);
        check("rst_after_fwd", {8'd0, fwd_byte}, 16'h55);
        send(8'h66);
        check_pkt("rst_after", 1'b1, 8'h55, 8'h66);
        pop_check("rst_pop0");
        pop_check("rst_pop1");
        handshake("rst_hs");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
